// File: rtl/chip_clock_seq.sv
// Chip clock and reset sequencer: divides the emulation clock into a single-phase
// chip clock, holds chip reset, and provides run / halt / single-step / soft-reset control.
module chip_clock_seq #(
    parameter int HALF_PERIOD  = 4,
    parameter int RESET_CYCLES = 8,
    parameter int COUNT_W      = 32
) (
    input  logic               eclk,
    input  logic               ereset_n,
    input  logic               run,
    input  logic               step,
    input  logic               rst_req,
    output logic               clk0,
    output logic               res,
    output logic               rise,
    output logic               fall,
    output logic               halted,
    output logic               step_done,
    output logic [COUNT_W-1:0] cycle_count
);

    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int HC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_IDLE = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [HC_W-1:0]  hold_cnt;
    logic             rst_flag;

    logic clk_en;
    logic tick;
    logic at_fall;
    logic rst_any;

    assign clk_en  = (state != S_IDLE);
    assign tick    = clk_en && (div == DIV_LAST);
    // every control decision is taken on the edge that drives clk0 low
    assign at_fall = tick && clk0;
    assign rst_any = rst_flag | rst_req;

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state       <= S_HOLD;
            div         <= '0;
            hold_cnt    <= '0;
            rst_flag    <= 1'b0;
            clk0        <= 1'b0;
            res         <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            halted      <= 1'b0;
            step_done   <= 1'b0;
            cycle_count <= '0;
        end else begin
            rise      <= 1'b0;
            fall      <= 1'b0;
            step_done <= 1'b0;
            halted    <= (state == S_IDLE);
            // res follows one edge behind leaving HOLD; HOLD entry forces it low below
            res       <= (state != S_HOLD);

            if (clk_en) begin
                if (tick) begin
                    div  <= '0;
                    clk0 <= ~clk0;
                    rise <= ~clk0;
                    fall <= clk0;
                end else begin
                    div <= div + 1'b1;
                end
            end

            case (state)
                S_HOLD: begin
                    if (rst_req) begin
                        hold_cnt <= '0;
                    end else if (at_fall) begin
                        if (hold_cnt == HC_LAST) begin
                            hold_cnt <= '0;
                            state    <= run ? S_RUN : S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (rst_req) rst_flag <= 1'b1;
                    if (at_fall) begin
                        if (rst_any) begin
                            state       <= S_HOLD;
                            res         <= 1'b0;
                            cycle_count <= '0;
                            rst_flag    <= 1'b0;
                            hold_cnt    <= '0;
                        end else begin
                            cycle_count <= cycle_count + 1'b1;
                            if (!run) state <= S_IDLE;
                        end
                    end
                end

                S_STEP: begin
                    if (rst_req) rst_flag <= 1'b1;
                    if (at_fall) begin
                        if (rst_any) begin
                            state       <= S_HOLD;
                            res         <= 1'b0;
                            cycle_count <= '0;
                            rst_flag    <= 1'b0;
                            hold_cnt    <= '0;
                        end else begin
                            cycle_count <= cycle_count + 1'b1;
                            step_done   <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                end

                S_IDLE: begin
                    // clock is already low with div at 0, so leaving restarts a clean low half
                    if (rst_req) begin
                        state       <= S_HOLD;
                        res         <= 1'b0;
                        cycle_count <= '0;
                        rst_flag    <= 1'b0;
                        hold_cnt    <= '0;
                    end else if (run) begin
                        state <= S_RUN;
                    end else if (step) begin
                        state <= S_STEP;
                    end
                end

                default: state <= S_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_clock_seq.sv
// Scoreboard bench for chip_clock_seq (HALF_PERIOD=2, RESET_CYCLES=3), with a
// COUNT_W=4 copy sharing stimulus to exercise counter wrap.
module tb_chip_clock_seq;

    logic        eclk = 1'b0;
    logic        ereset_n;
    logic        run, step, rst_req;
    logic        clk0, res, rise, fall, halted, step_done;
    logic [31:0] cycle_count;
    logic        clk0_4, res_4, rise_4, fall_4, halted_4, step_done_4;
    logic [3:0]  cycle_count_4;

    int checks = 0;
    int failures = 0;
    int ec = 0;
    int base = 0;

    typedef struct {
        int          e;
        string       tag;
        logic [5:0]  sig;   // {clk0,res,rise,fall,halted,step_done}
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    always #5 eclk = ~eclk;

    chip_clock_seq #(.HALF_PERIOD(2), .RESET_CYCLES(3), .COUNT_W(32)) dut (
        .eclk(eclk), .ereset_n(ereset_n), .run(run), .step(step), .rst_req(rst_req),
        .clk0(clk0), .res(res), .rise(rise), .fall(fall), .halted(halted),
        .step_done(step_done), .cycle_count(cycle_count)
    );

    chip_clock_seq #(.HALF_PERIOD(2), .RESET_CYCLES(3), .COUNT_W(4)) dut4 (
        .eclk(eclk), .ereset_n(ereset_n), .run(run), .step(step), .rst_req(rst_req),
        .clk0(clk0_4), .res(res_4), .rise(rise_4), .fall(fall_4), .halted(halted_4),
        .step_done(step_done_4), .cycle_count(cycle_count_4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input string tag, input logic [5:0] sig, input logic [31:0] cnt);
        exp_t x;
        x.e = base + n;
        x.tag = tag;
        x.sig = sig;
        x.cnt = cnt;
        q.push_back(x);
    endtask

    // return at the falling eclk edge following relative edge n
    task automatic at(input int n);
        while (ec < base + n) @(negedge eclk);
    endtask

    always begin
        exp_t x;
        @(posedge eclk);
        ec++;
        #1;
        while (q.size() > 0 && q[0].e <= ec) begin
            x = q.pop_front();
            chk({x.tag, "_edge"}, 64'(ec), 64'(x.e));
            chk({x.tag, "_sig"}, {clk0, res, rise, fall, halted, step_done}, x.sig);
            chk({x.tag, "_cnt"}, cycle_count, x.cnt);
            chk({x.tag, "_sig4"}, {clk0_4, res_4, rise_4, fall_4, halted_4, step_done_4}, x.sig);
            chk({x.tag, "_cnt4"}, cycle_count_4, x.cnt[3:0]);
        end
    end

    initial begin
        ereset_n = 1'b0;
        run = 1'b1;
        step = 1'b0;
        rst_req = 1'b0;
        #2;
        chk("rst_outs", {clk0, res, rise, fall, halted, step_done}, 6'b0);
        chk("rst_cnt", cycle_count, 0);

        repeat (3) @(negedge eclk);
        ereset_n = 1'b1;
        base = ec;

        // power-on hold with run=1
        push(1,  "s1_e1",   6'b000000, 0);
        push(2,  "s1_r1",   6'b101000, 0);
        push(4,  "s1_f1",   6'b000100, 0);
        push(6,  "s1_r2",   6'b101000, 0);
        push(8,  "s1_f2",   6'b000100, 0);
        push(10, "s1_r3",   6'b101000, 0);
        push(12, "s1_f3",   6'b000100, 0);
        push(13, "s1_res",  6'b010000, 0);
        push(14, "s1_r4",   6'b111000, 0);
        push(16, "s1_f4",   6'b010100, 1);

        // drop run during the high phase
        at(18);
        run = 1'b0;
        push(20, "s2_fall", 6'b010100, 2);
        push(21, "s2_halt", 6'b010010, 2);
        push(24, "s2_idle", 6'b010010, 2);

        // single step, with a second step ignored mid-step
        at(25);
        step = 1'b1;
        push(27, "s3_busy", 6'b010000, 2);
        push(28, "s3_rise", 6'b111000, 2);
        push(30, "s3_done", 6'b010101, 3);
        push(31, "s3_halt", 6'b010010, 3);
        push(32, "s3_idl1", 6'b010010, 3);
        push(33, "s3_idl2", 6'b010010, 3);
        push(34, "s3_idl3", 6'b010010, 3);
        at(26);
        step = 1'b0;
        at(28);
        step = 1'b1;
        at(29);
        step = 1'b0;

        // resume run, then soft reset mid-cycle
        at(35);
        run = 1'b1;
        push(36, "s4_wake", 6'b010010, 3);
        push(38, "s4_rise", 6'b111000, 3);
        push(40, "s4_fall", 6'b010100, 4);
        at(42);
        rst_req = 1'b1;
        push(44, "s4_hold", 6'b000100, 0);
        push(46, "s4_hr1",  6'b101000, 0);
        push(56, "s4_hf3",  6'b000100, 0);
        push(57, "s4_res",  6'b010000, 0);
        push(58, "s4_rr",   6'b111000, 0);
        push(60, "s4_rf",   6'b010100, 1);
        at(43);
        rst_req = 1'b0;

        // halt, then soft reset from IDLE
        at(61);
        run = 1'b0;
        push(64, "s5_fall", 6'b010100, 2);
        push(65, "s5_halt", 6'b010010, 2);
        at(66);
        rst_req = 1'b1;
        push(67, "s5_hold", 6'b000010, 0);
        push(68, "s5_h1",   6'b000000, 0);
        push(69, "s5_hr",   6'b101000, 0);
        push(79, "s5_hf3",  6'b000100, 0);
        push(80, "s5_res",  6'b010010, 0);
        at(67);
        rst_req = 1'b0;

        // async reset in a high phase
        at(82);
        run = 1'b1;
        push(85, "s6_rise", 6'b111000, 0);
        push(87, "s6_fall", 6'b010100, 1);
        at(89);
        chk("s6_high", clk0, 1'b1);
        ereset_n = 1'b0;
        #1;
        chk("s6_async_outs", {clk0, res, rise, fall, halted, step_done}, 6'b0);
        chk("s6_async_cnt", cycle_count, 0);
        chk("s6_async_cnt4", cycle_count_4, 0);
        chk("s6_q_empty", q.size(), 0);

        // free run long enough for the 4-bit counter to wrap
        repeat (2) @(negedge eclk);
        ereset_n = 1'b1;
        base = ec;
        push(12, "s7_hf3", 6'b000100, 0);
        push(13, "s7_res", 6'b010000, 0);
        for (int k = 0; k < 20; k++)
            push(16 + 4 * k, $sformatf("s7_f%0d", k + 1), 6'b010100, 32'(k + 1));
        at(95);
        chk("end_q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
